// File: rtl/burst_bus_arbiter_pkg.sv
// Shared types and constants for the burst memory port arbiter and its clients.
package burst_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WR_BEATS,
        ARB_RD_WAIT
    } arb_state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Wide enough for beat indices 0..15 (bursts of up to 16 beats).
    localparam int unsigned BEAT_CNT_W = 4;

endpackage

// File: rtl/burst_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module burst_bus_arbiter_rr_priority_picker #(
    parameter int unsigned N   = 3,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           valid_o
);

    int unsigned k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        for (int unsigned off = 0; off < N; off++) begin
            k = (32'(ptr_i) + off) % N;
            if (!valid_o && req_i[IDW'(k)]) begin
                valid_o            = 1'b1;
                gnt_o[IDW'(k)]     = 1'b1;
                idx_o              = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/burst_bus_arbiter.sv
// Round-robin arbiter sharing one burst memory controller port among several masters;
// the port stays locked to the winner until its write or read burst completes.
module burst_bus_arbiter
    import burst_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_WIDTH  = 21,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned BURST_BEATS = 4,
    parameter int unsigned IDW         = $clog2(NUM_MASTERS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_MASTERS-1:0]             m_cmd_en,
    input  logic [NUM_MASTERS-1:0]             m_cmd,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_wr_data,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0]  m_data_mask,
    output logic [NUM_MASTERS-1:0]             m_ready,
    output logic [DATA_WIDTH-1:0]              m_rd_data,
    output logic [NUM_MASTERS-1:0]             m_rd_data_valid,
    output logic                               s_cmd_en,
    output logic                               s_cmd,
    output logic [ADDR_WIDTH-1:0]              s_addr,
    output logic [DATA_WIDTH-1:0]              s_wr_data,
    output logic [MASK_WIDTH-1:0]              s_data_mask,
    input  logic                               s_ready,
    input  logic [DATA_WIDTH-1:0]              s_rd_data,
    input  logic                               s_rd_data_valid,
    output logic                               busy,
    output logic [IDW-1:0]                     owner
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_BEATS - 1);
    // Write beat 0 is the accept cycle, so WR_BEATS only walks beats 1..BURST_BEATS-1.
    localparam logic [BEAT_CNT_W-1:0] LAST_WR_CNT =
        BEAT_CNT_W'((BURST_BEATS >= 2) ? BURST_BEATS - 2 : 0);

    arb_state_e              state_q, state_d;
    logic [IDW-1:0]          owner_q, owner_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_MASTERS-1:0]  win_gnt;
    logic [IDW-1:0]          win_idx;
    logic                    win_valid;
    logic                    idle;
    logic                    accept;
    logic [IDW-1:0]          sel;

    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]   data_arr [NUM_MASTERS];
    logic [MASK_WIDTH-1:0]   mask_arr [NUM_MASTERS];

    burst_bus_arbiter_rr_priority_picker #(
        .N   (NUM_MASTERS),
        .IDW (IDW)
    ) u_picker (
        .req_i   (m_cmd_en),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (win_gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            addr_arr[i] = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            mask_arr[i] = m_data_mask[i*MASK_WIDTH +: MASK_WIDTH];
        end
    end

    assign idle   = (state_q == ARB_IDLE) && !reset;
    assign accept = idle && win_valid && s_ready;
    // Winner drives the port in the accept cycle, the locked owner afterwards.
    assign sel    = (state_q == ARB_IDLE) ? win_idx : owner_q;

    always_comb begin
        m_ready = '0;
        if (idle && s_ready) begin
            m_ready = win_valid ? win_gnt : {NUM_MASTERS{1'b1}};
        end
        m_rd_data_valid = '0;
        if (!reset && (state_q == ARB_RD_WAIT) && s_rd_data_valid) begin
            m_rd_data_valid[owner_q] = 1'b1;
        end
    end

    assign s_cmd_en    = accept;
    assign s_cmd       = m_cmd[sel];
    assign s_addr      = addr_arr[sel];
    assign s_wr_data   = data_arr[sel];
    assign s_data_mask = mask_arr[sel];
    assign m_rd_data   = s_rd_data;
    assign busy        = !reset && (state_q != ARB_IDLE);
    assign owner       = owner_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    owner_d    = win_idx;
                    rr_ptr_d   = (win_idx == IDW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
                    beat_cnt_d = '0;
                    if (m_cmd[win_idx] == CMD_WRITE) begin
                        state_d = (BURST_BEATS == 1) ? ARB_IDLE : ARB_WR_BEATS;
                    end else begin
                        state_d = ARB_RD_WAIT;
                    end
                end
            end
            ARB_WR_BEATS: begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (beat_cnt_q == LAST_WR_CNT) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_RD_WAIT: begin
                if (s_rd_data_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_burst_bus_arbiter.sv
// Directed self-checking bench for burst_bus_arbiter with 3 masters and 4-beat bursts.
module tb_burst_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 21;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int BB = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        m_cmd_en;
    logic [N-1:0]        m_cmd;
    logic [N*AW-1:0]     m_addr;
    logic [N*DW-1:0]     m_wr_data;
    logic [N*MW-1:0]     m_data_mask;
    logic [N-1:0]        m_ready;
    logic [DW-1:0]       m_rd_data;
    logic [N-1:0]        m_rd_data_valid;
    logic                s_cmd_en;
    logic                s_cmd;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wr_data;
    logic [MW-1:0]       s_data_mask;
    logic                s_ready;
    logic [DW-1:0]       s_rd_data;
    logic                s_rd_data_valid;
    logic                busy;
    logic [IW-1:0]       owner;

    int tests  = 0;
    int errors = 0;

    burst_bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MASK_WIDTH  (MW),
        .BURST_BEATS (BB),
        .IDW         (IW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m_cmd_en        (m_cmd_en),
        .m_cmd           (m_cmd),
        .m_addr          (m_addr),
        .m_wr_data       (m_wr_data),
        .m_data_mask     (m_data_mask),
        .m_ready         (m_ready),
        .m_rd_data       (m_rd_data),
        .m_rd_data_valid (m_rd_data_valid),
        .s_cmd_en        (s_cmd_en),
        .s_cmd           (s_cmd),
        .s_addr          (s_addr),
        .s_wr_data       (s_wr_data),
        .s_data_mask     (s_data_mask),
        .s_ready         (s_ready),
        .s_rd_data       (s_rd_data),
        .s_rd_data_valid (s_rd_data_valid),
        .busy            (busy),
        .owner           (owner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_cmd_en = 3'b001;
        s_rd_data_valid = 1'b1;
        step();
        step();
        #1;
        tests++;
        if (m_ready !== 3'b000 || s_cmd_en !== 1'b0 || m_rd_data_valid !== 3'b000
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b cmd_en=%b rdv=%b busy=%b, want 000 0 000 0",
                     m_ready, s_cmd_en, m_rd_data_valid, busy);
        end
        m_cmd_en = '0;
        s_rd_data_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++;
        if (owner !== 2'd0 || busy !== 1'b0 || m_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_idle: got owner=%0d busy=%b ready=%b, want 0 0 111",
                     owner, busy, m_ready);
        end
    endtask

    task automatic test_single_read();
        int bad;
        step();
        m_cmd_en = 3'b010;
        m_cmd = 3'b000;
        m_addr = {21'h1FFFF, 21'h01234, 21'h0AAAA};
        #1;
        tests++;
        if (s_cmd_en !== 1'b1 || s_addr !== 21'h01234 || s_cmd !== 1'b0 || m_ready !== 3'b010)
        begin
            errors++;
            $display("FAIL rd_accept: got en=%b addr=%h cmd=%b ready=%b, want 1 01234 0 010",
                     s_cmd_en, s_addr, s_cmd, m_ready);
        end
        step();
        m_cmd_en = '0;
        #1;
        tests++;
        if (busy !== 1'b1 || owner !== 2'd1 || m_ready !== 3'b000) begin
            errors++;
            $display("FAIL rd_locked: got busy=%b owner=%0d ready=%b, want 1 1 000",
                     busy, owner, m_ready);
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (m_rd_data_valid !== 3'b000 || busy !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rd_latency_wait: got %0d bad cycles, want 0", bad);
        end
        for (int b = 0; b < BB; b++) begin
            step();
            s_rd_data_valid = 1'b1;
            s_rd_data = 64'hBEEF_0000_0000_0000 + 64'(b);
            #1;
            tests++;
            if (m_rd_data_valid !== 3'b010 || m_rd_data !== 64'hBEEF_0000_0000_0000 + 64'(b)
                || busy !== 1'b1) begin
                errors++;
                $display("FAIL rd_beat%0d: got rdv=%b data=%h busy=%b, want 010 %h 1",
                         b, m_rd_data_valid, m_rd_data, busy, 64'hBEEF_0000_0000_0000 + 64'(b));
            end
        end
        step();
        s_rd_data_valid = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || m_rd_data_valid !== 3'b000) begin
            errors++;
            $display("FAIL rd_done: got busy=%b rdv=%b, want 0 000", busy, m_rd_data_valid);
        end
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] d [BB];
        for (int b = 0; b < BB; b++) d[b] = 64'hD0D0_1111_0000_0000 + 64'(b * 3 + 1);
        m_cmd_en = 3'b100;
        m_cmd = 3'b100;
        m_addr = {21'h00100, 21'h01234, 21'h0AAAA};
        m_wr_data = {d[0], 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        m_data_mask = {8'h00, 8'hFF, 8'hFF};
        #1;
        tests++;
        if (s_cmd_en !== 1'b1 || s_cmd !== 1'b1 || s_addr !== 21'h00100 || s_wr_data !== d[0]
            || s_data_mask !== 8'h00 || m_ready !== 3'b100) begin
            errors++;
            $display("FAIL wr_accept: got en=%b cmd=%b addr=%h data=%h mask=%h ready=%b",
                     s_cmd_en, s_cmd, s_addr, s_wr_data, s_data_mask, m_ready);
        end
        for (int b = 1; b < BB; b++) begin
            step();
            m_cmd_en = '0;
            m_wr_data[2*DW +: DW] = d[b];
            s_rd_data_valid = (b == 2);
            #1;
            tests++;
            if (s_wr_data !== d[b] || s_data_mask !== 8'h00 || m_ready !== 3'b000
                || s_cmd_en !== 1'b0 || busy !== 1'b1 || m_rd_data_valid !== 3'b000) begin
                errors++;
                $display("FAIL wr_beat%0d: got data=%h mask=%h ready=%b en=%b busy=%b rdv=%b",
                         b, s_wr_data, s_data_mask, m_ready, s_cmd_en, busy, m_rd_data_valid);
            end
        end
        step();
        s_rd_data_valid = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || owner !== 2'd2 || m_ready !== 3'b111) begin
            errors++;
            $display("FAIL wr_done: got busy=%b owner=%0d ready=%b, want 0 2 111",
                     busy, owner, m_ready);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_oh;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_cmd_en = 3'b111;
        m_cmd = 3'b000;
        m_addr = {21'h00333, 21'h00222, 21'h00111};
        for (int g = 0; g < 6; g++) begin
            exp_oh = 3'b001 << (g % 3);
            #1;
            tests++;
            if (m_ready !== exp_oh || s_cmd_en !== 1'b1
                || s_addr !== 21'(21'h00111 * ((g % 3) + 1))) begin
                errors++;
                $display("FAIL rr_grant%0d: got ready=%b en=%b addr=%h, want %b 1 %h",
                         g, m_ready, s_cmd_en, s_addr, exp_oh, 21'(21'h00111 * ((g % 3) + 1)));
            end
            step();
            for (int b = 0; b < BB; b++) begin
                s_rd_data_valid = 1'b1;
                #1;
                tests++;
                if (m_rd_data_valid !== exp_oh || busy !== 1'b1 || owner !== 2'(g % 3)) begin
                    errors++;
                    $display("FAIL rr_beat%0d_%0d: got rdv=%b busy=%b owner=%0d, want %b 1 %0d",
                             g, b, m_rd_data_valid, busy, owner, exp_oh, g % 3);
                end
                step();
            end
            s_rd_data_valid = 1'b0;
        end
        m_cmd_en = '0;
    endtask

    task automatic test_s_ready_low();
        s_ready = 1'b0;
        m_cmd_en = 3'b001;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (s_cmd_en !== 1'b0 || m_ready !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL sready_hold%0d: got en=%b ready=%b busy=%b, want 0 000 0",
                         c, s_cmd_en, m_ready, busy);
            end
            step();
        end
        s_ready = 1'b1;
        #1;
        tests++;
        if (s_cmd_en !== 1'b1 || m_ready !== 3'b001) begin
            errors++;
            $display("FAIL sready_accept: got en=%b ready=%b, want 1 001", s_cmd_en, m_ready);
        end
        step();
        m_cmd_en = '0;
        #1;
        tests++;
        if (busy !== 1'b1 || owner !== 2'd0) begin
            errors++;
            $display("FAIL sready_locked: got busy=%b owner=%0d, want 1 0", busy, owner);
        end
        for (int b = 0; b < BB; b++) begin
            s_rd_data_valid = 1'b1;
            step();
        end
        s_rd_data_valid = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sready_done: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_read();
        m_cmd_en = 3'b010;
        #1;
        tests++;
        if (m_ready !== 3'b010) begin
            errors++;
            $display("FAIL rst_mid_grant: got ready=%b, want 010", m_ready);
        end
        step();
        m_cmd_en = '0;
        for (int b = 0; b < 2; b++) begin
            s_rd_data_valid = 1'b1;
            #1;
            tests++;
            if (m_rd_data_valid !== 3'b010) begin
                errors++;
                $display("FAIL rst_mid_beat%0d: got rdv=%b, want 010", b, m_rd_data_valid);
            end
            step();
        end
        reset = 1'b1;
        #1;
        tests++;
        if (m_rd_data_valid !== 3'b000 || busy !== 1'b0 || m_ready !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_during: got rdv=%b busy=%b ready=%b, want 000 0 000",
                     m_rd_data_valid, busy, m_ready);
        end
        step();
        reset = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || owner !== 2'd0 || m_rd_data_valid !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_after: got busy=%b owner=%0d rdv=%b, want 0 0 000",
                     busy, owner, m_rd_data_valid);
        end
        step();
        tests++;
        if (m_rd_data_valid !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stray: got rdv=%b busy=%b, want 000 0", m_rd_data_valid, busy);
        end
        s_rd_data_valid = 1'b0;
        // Pointer back at 0 means master 1 beats master 2.
        m_cmd_en = 3'b110;
        #1;
        tests++;
        if (m_ready !== 3'b010) begin
            errors++;
            $display("FAIL rst_mid_rrptr: got ready=%b, want 010", m_ready);
        end
        m_cmd_en = '0;
    endtask

    task automatic test_stray_idle();
        s_rd_data_valid = 1'b1;
        #1;
        tests++;
        if (m_rd_data_valid !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: got rdv=%b busy=%b, want 000 0", m_rd_data_valid, busy);
        end
        step();
        s_rd_data_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_cmd_en = '0;
        m_cmd = '0;
        m_addr = '0;
        m_wr_data = '0;
        m_data_mask = '0;
        s_ready = 1'b1;
        s_rd_data = '0;
        s_rd_data_valid = 1'b0;
        test_reset();
        test_single_read();
        test_write_burst();
        test_contention();
        test_s_ready_low();
        test_reset_mid_read();
        test_stray_idle();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
